// File: rtl/selection_pkg.sv
// GA-wide sizing shared by the fitness, selection and mutation stages.
package selection_pkg;
  localparam int NUM_PATHS = 50;
  localparam int NUM_SEL   = 10;
  localparam int PATH_W    = 150;
  localparam int FIT_W     = 16;
  localparam int POP_W     = NUM_PATHS * PATH_W;
  localparam int SEL_W     = NUM_SEL * PATH_W;
  localparam int FIT_BUS_W = NUM_PATHS * FIT_W;
  localparam int IDX_W     = 6;
  localparam int SLOT_W    = 4;
endpackage

// File: rtl/selection_sel_min_tracker.sv
// Running minimum over one scan pass: keeps the fittest not-yet-picked path seen so far.
module sel_min_tracker
  import selection_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             cand_skip,
  input  logic [FIT_W-1:0] cand_fit,
  input  logic [IDX_W-1:0] cand_idx,
  output logic [IDX_W-1:0] best_idx
);
  logic [FIT_W-1:0] best_fit_q, best_fit_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             best_valid_q, best_valid_d;

  // Strict less-than keeps the earlier index on equal fitness.
  always_comb begin
    best_fit_d   = best_fit_q;
    best_idx_d   = best_idx_q;
    best_valid_d = best_valid_q;
    if (clr) begin
      best_valid_d = 1'b0;
    end else if (en && !cand_skip && (!best_valid_q || cand_fit < best_fit_q)) begin
      best_fit_d   = cand_fit;
      best_idx_d   = cand_idx;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_fit_q   <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_fit_q   <= best_fit_d;
      best_idx_q   <= best_idx_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_idx = best_idx_q;
endmodule

// File: rtl/selection.sv
// Selects the NUM_SEL fittest paths by repeated min-scans, one slot per 51-cycle pass.
//   state | meaning
//   IDLE  | waiting for start (ignored while the done pulse is out)
//   SCAN  | one fitness compare per cycle over all paths
//   STORE | copy winning path into its slot, mark it picked
//   DONE  | last slot written; done pulses on the following cycle
module selection
  import selection_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [POP_W-1:0]     population,
  input  logic [FIT_BUS_W-1:0] fitness,
  output logic [SEL_W-1:0]     sel_population,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, SCAN, STORE, DONE} state_e;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PATHS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SEL - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [NUM_PATHS-1:0]  picked_q, picked_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  done_q, done_d;
  logic                  trk_clr, trk_en;
  logic [IDX_W-1:0]      best_idx;
  logic [FIT_W-1:0]      cand_fit;

  assign cand_fit = fitness[int'(idx_q) * FIT_W +: FIT_W];

  sel_min_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clr       (trk_clr),
    .en        (trk_en),
    .cand_skip (picked_q[idx_q]),
    .cand_fit  (cand_fit),
    .cand_idx  (idx_q),
    .best_idx  (best_idx)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    picked_d = picked_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    trk_clr  = 1'b0;
    trk_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d  = SCAN;
          picked_d = '0;
          idx_d    = '0;
          slot_d   = '0;
          trk_clr  = 1'b1;
        end
      end
      SCAN: begin
        trk_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = STORE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      STORE: begin
        sel_d[int'(slot_q) * PATH_W +: PATH_W] = population[int'(best_idx) * PATH_W +: PATH_W];
        picked_d[best_idx] = 1'b1;
        slot_d  = slot_q + SLOT_W'(1);
        idx_d   = '0;
        trk_clr = 1'b1;
        state_d = (slot_q == LAST_SLOT) ? DONE : SCAN;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      slot_q   <= '0;
      picked_q <= '0;
      sel_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      picked_q <= picked_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
    end
  end

  assign sel_population = sel_q;
  assign done           = done_q;
endmodule
